// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
// The optional bus watchdog is enabled by defining MEM_ACCESS_TIMEOUT_EN.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // Load data returned when an access is abandoned by the watchdog
    localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for an outstanding data-memory request. Counts REQ cycles that
// pass without an acknowledge and flags expiry on the cycle the count
// reaches TIMEOUT-1. Only instantiated when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic expired
);

    logic [7:0] count;

    // An ack on the final cycle wins, so expiry is suppressed whenever ack is high
    assign expired = active && !ack && (count == 8'(TIMEOUT - 1));

    // Restart at every REQ entry, advance on each REQ cycle left unanswered
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (active && !ack && !expired) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: runs loads/stores over a req/ack data bus with
// variable latency, stalls the upstream pipeline while an access is
// outstanding, and registers the MEM/WB bundle.
// Optional bus watchdog: define MEM_ACCESS_TIMEOUT_EN.
//
// Bus handshake: dmem_req rises on the edge leaving IDLE and stays high with
// dmem_we/addr/wdata frozen until the first cycle in which dmem_ack is seen
// (dmem_rdata is valid in that same cycle); dmem_req drops on that edge.
// dmem_ack outside a pending request is ignored.
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_next_pc,
    input  logic [DATA_W-1:0] mem_alu_out,
    input  logic [DATA_W-1:0] mem_reg_mem,
    input  logic [4:0]        mem_write_reg,
    input  logic              mem_mem_write,
    input  logic              mem_reg_src,
    input  logic              mem_reg_write,
    input  logic              mem_jal,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic [DATA_W-1:0] wb_next_pc,
    output logic [DATA_W-1:0] wb_alu_out,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [4:0]        wb_write_reg,
    output logic              wb_reg_src,
    output logic              wb_reg_write,
    output logic              wb_jal,
    output logic              bus_err,
    output logic [1:0]        dbg_state
);

    import mips_pkg::*;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_access_ctrl: TIMEOUT must lie in 1..255");
    end

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic              mem_op;
    logic              is_load;
    logic              enter_req;
    logic              timeout_hit;
    logic [DATA_W-1:0] load_buf;

    // A set store bit dominates: load+store together behaves as a store
    assign mem_op  = mem_reg_src | mem_mem_write;
    assign is_load = mem_reg_src & ~mem_mem_write;

`ifdef MEM_ACCESS_TIMEOUT_EN
    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clock   (clock),
        .reset   (reset),
        .clear   (enter_req),
        .active  (state == REQ),
        .ack     (dmem_ack),
        .expired (timeout_hit)
    );

    // Error pulse coincides with the DONE cycle of an aborted access
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> REQ on a memory op, REQ -> DONE on ack or abort
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_op) state_nxt = REQ;
            REQ:     if (dmem_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: stall holds the EX/MEM instruction in place
    always_comb begin
        stall     = 1'b0;
        enter_req = 1'b0;
        dbg_state = state;
        case (state)
            IDLE: begin
                stall     = mem_op;
                enter_req = mem_op;
            end
            REQ:     stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Bus request registers and load buffer
    always_ff @(posedge clock) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            load_buf   <= '0;
        end else begin
            if (enter_req) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_mem_write;
                dmem_addr  <= mem_alu_out;
                dmem_wdata <= mem_reg_mem;
            end else if (state == REQ && (dmem_ack || timeout_hit)) begin
                dmem_req <= 1'b0;
            end

            if (state == REQ && dmem_ack) begin
                load_buf <= dmem_rdata;
            end else if (state == REQ && timeout_hit) begin
                load_buf <= DATA_W'(BAD_DATA);
            end
        end
    end

    // MEM/WB register: bubble while stalled, capture the bundle otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_next_pc   <= '0;
            wb_alu_out   <= '0;
            wb_mem_data  <= '0;
            wb_write_reg <= '0;
            wb_reg_src   <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_jal       <= 1'b0;
        end else if (stall) begin
            wb_reg_write <= 1'b0;
            wb_jal       <= 1'b0;
        end else begin
            wb_next_pc   <= mem_next_pc;
            wb_alu_out   <= mem_alu_out;
            wb_mem_data  <= (state == DONE && is_load) ? load_buf : '0;
            wb_write_reg <= mem_write_reg;
            wb_reg_src   <= mem_reg_src;
            wb_reg_write <= mem_reg_write;
            wb_jal       <= mem_jal;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. Instructions are issued one at a
// time; a transaction-level model predicts stall length, bus fields and the
// resulting write-back bundle. Define MEM_ACCESS_TIMEOUT_EN to also cover
// the watchdog.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int DW         = 32;
    localparam int TB_TIMEOUT = 4;
    localparam int MAX_CYC    = 64;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] alu;
        logic [DW-1:0] sdata;
        logic [4:0]    rd;
        logic          st;
        logic          ld;
        logic          rw;
        logic          jal;
    } instr_t;

    logic          clock;
    logic          reset;
    logic [DW-1:0] mem_next_pc;
    logic [DW-1:0] mem_alu_out;
    logic [DW-1:0] mem_reg_mem;
    logic [4:0]    mem_write_reg;
    logic          mem_mem_write;
    logic          mem_reg_src;
    logic          mem_reg_write;
    logic          mem_jal;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;
    logic          stall;
    logic [DW-1:0] wb_next_pc;
    logic [DW-1:0] wb_alu_out;
    logic [DW-1:0] wb_mem_data;
    logic [4:0]    wb_write_reg;
    logic          wb_reg_src;
    logic          wb_reg_write;
    logic          wb_jal;
    logic          bus_err;
    logic [1:0]    dbg_state;

    mem_access_ctrl #(
        .DATA_W  (DW),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_next_pc   (mem_next_pc),
        .mem_alu_out   (mem_alu_out),
        .mem_reg_mem   (mem_reg_mem),
        .mem_write_reg (mem_write_reg),
        .mem_mem_write (mem_mem_write),
        .mem_reg_src   (mem_reg_src),
        .mem_reg_write (mem_reg_write),
        .mem_jal       (mem_jal),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .stall         (stall),
        .wb_next_pc    (wb_next_pc),
        .wb_alu_out    (wb_alu_out),
        .wb_mem_data   (wb_mem_data),
        .wb_write_reg  (wb_write_reg),
        .wb_reg_src    (wb_reg_src),
        .wb_reg_write  (wb_reg_write),
        .wb_jal        (wb_jal),
        .bus_err       (bus_err),
        .dbg_state     (dbg_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard state
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_instr(input instr_t in);
        mem_next_pc   = in.pc;
        mem_alu_out   = in.alu;
        mem_reg_mem   = in.sdata;
        mem_write_reg = in.rd;
        mem_mem_write = in.st;
        mem_reg_src   = in.ld;
        mem_reg_write = in.rw;
        mem_jal       = in.jal;
    endtask

    task automatic check_wb_zero(input string tag);
        check({tag, "_pc"},  wb_next_pc,   '0);
        check({tag, "_alu"}, wb_alu_out,   '0);
        check({tag, "_md"},  wb_mem_data,  '0);
        check({tag, "_rd"},  {27'd0, wb_write_reg}, '0);
        check({tag, "_ctl"}, {29'd0, wb_reg_src, wb_reg_write, wb_jal}, '0);
    endtask

    // Issue one instruction (entered at a falling edge) and check it end to end.
    // ack_delay: REQ cycle (1-based) in which the memory acknowledges.
    task automatic run_instr(input instr_t in, input int ack_delay,
                             input logic [DW-1:0] rdata, input bit spurious_ack);
        bit            is_mem;
        bit            tmo;
        bit            done;
        int            eff;
        int            stalls;
        int            reqs;
        logic [DW-1:0] exp_md;

        is_mem = in.ld | in.st;
        tmo    = 1'b0;
        eff    = ack_delay;
`ifdef MEM_ACCESS_TIMEOUT_EN
        if (is_mem && ack_delay > TB_TIMEOUT) begin
            tmo = 1'b1;
            eff = TB_TIMEOUT;
        end
`endif
        if (in.ld && !in.st) exp_md = tmo ? 32'hDEADBEEF : rdata;
        else                 exp_md = '0;
        exp_q.push_back(exp_md);

        drive_instr(in);
        stalls = 0;
        reqs   = 0;
        done   = 1'b0;
        for (int c = 0; c < MAX_CYC; c++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            if (stalls >= 1) begin
                check("bubble_rw",  {31'd0, wb_reg_write}, 32'd0);
                check("bubble_jal", {31'd0, wb_jal}, 32'd0);
            end
            if (stalls == 1) check("req_rise", {31'd0, dmem_req}, 32'd1);
            check("err_quiet", {31'd0, bus_err}, 32'd0);
            if (dmem_req) begin
                reqs++;
                check("bus_addr",  dmem_addr, in.alu);
                check("bus_we",    {31'd0, dmem_we}, {31'd0, in.st});
                check("bus_wdata", dmem_wdata, in.sdata);
                if (reqs == ack_delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            stalls++;
            @(negedge clock);
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom();
        end
        check("stall_bound", {31'd0, done}, 32'd1);
        if (!done) #1;

        // Completing cycle: IDLE for ALU ops, DONE for memory ops
        check("stall_len", stalls, is_mem ? 1 + eff : 0);
        check("req_cycles", reqs, is_mem ? eff : 0);
        check("req_low", {31'd0, dmem_req}, 32'd0);
        check("bus_err", {31'd0, bus_err}, {31'd0, tmo});
        if (spurious_ack) begin
            dmem_ack   = 1'b1;
            dmem_rdata = $urandom();
        end
        @(negedge clock);
        dmem_ack = 1'b0;
        #1;
        check("wb_pc",   wb_next_pc, in.pc);
        check("wb_alu",  wb_alu_out, in.alu);
        check("wb_md",   wb_mem_data, exp_q.pop_front());
        check("wb_rd",   {27'd0, wb_write_reg}, {27'd0, in.rd});
        check("wb_src",  {31'd0, wb_reg_src}, {31'd0, in.ld});
        check("wb_rw",   {31'd0, wb_reg_write}, {31'd0, in.rw});
        check("wb_jal",  {31'd0, wb_jal}, {31'd0, in.jal});
        check("err_end", {31'd0, bus_err}, 32'd0);
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        int     kind;
        r.pc    = $urandom();
        r.alu   = $urandom();
        r.sdata = $urandom();
        r.rd    = 5'($urandom_range(0, 31));
        r.rw    = 1'b0;
        r.jal   = 1'b0;
        r.ld    = 1'b0;
        r.st    = 1'b0;
        kind    = $urandom_range(0, 4);
        case (kind)
            0: r.rw = 1'b1;
            1: begin r.ld = 1'b1; r.rw = 1'b1; end
            2: r.st = 1'b1;
            3: begin r.jal = 1'b1; r.rw = 1'b1; end
            default: begin r.ld = 1'b1; r.st = 1'b1; r.rw = 1'($urandom_range(0, 1)); end
        endcase
        return r;
    endfunction

    instr_t ins;

    initial begin
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        ins        = '0;
        drive_instr(ins);
        repeat (2) @(negedge clock);
        #1;
        check("rst_req",   {31'd0, dmem_req}, 32'd0);
        check("rst_we",    {31'd0, dmem_we}, 32'd0);
        check("rst_addr",  dmem_addr, '0);
        check("rst_wdata", dmem_wdata, '0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_err",   {31'd0, bus_err}, 32'd0);
        check_wb_zero("rst_wb");
        @(negedge clock);
        reset = 1'b0;

        // ALU op: rd=5, alu_out=0x10
        ins = '0; ins.rw = 1'b1; ins.rd = 5'd5; ins.alu = 32'h10; ins.pc = 32'h4;
        run_instr(ins, 1, '0, 1'b0);
        // Load from 0x100, ack in the third REQ cycle
        ins = '0; ins.ld = 1'b1; ins.rw = 1'b1; ins.rd = 5'd7; ins.alu = 32'h100; ins.pc = 32'h8;
        run_instr(ins, 3, 32'hCAFEF00D, 1'b1);
        // Store 0x12345678 to 0x200, ack in the first REQ cycle
        ins = '0; ins.st = 1'b1; ins.sdata = 32'h12345678; ins.alu = 32'h200; ins.pc = 32'hC;
        run_instr(ins, 1, 32'h0BAD0BAD, 1'b0);
        // Two back-to-back loads with immediate ack, unaligned address included
        ins = '0; ins.ld = 1'b1; ins.rw = 1'b1; ins.rd = 5'd1; ins.alu = 32'h303; ins.pc = 32'h10;
        run_instr(ins, 1, 32'h11111111, 1'b0);
        ins = '0; ins.ld = 1'b1; ins.rw = 1'b1; ins.rd = 5'd2; ins.alu = 32'h304; ins.pc = 32'h14;
        run_instr(ins, 1, 32'h22222222, 1'b0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Load with no ack: aborted after TB_TIMEOUT REQ cycles
        ins = '0; ins.ld = 1'b1; ins.rw = 1'b1; ins.rd = 5'd3; ins.alu = 32'h400; ins.pc = 32'h18;
        run_instr(ins, 1000, 32'h0, 1'b0);
        // Ack arriving on the would-be timeout cycle wins
        ins = '0; ins.ld = 1'b1; ins.rw = 1'b1; ins.rd = 5'd4; ins.alu = 32'h404; ins.pc = 32'h1C;
        run_instr(ins, TB_TIMEOUT, 32'h5A5A5A5A, 1'b0);
`endif

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            ins = rand_instr();
`ifdef MEM_ACCESS_TIMEOUT_EN
            run_instr(ins, $urandom_range(1, TB_TIMEOUT + 2), $urandom(), 1'($urandom_range(0, 1)));
`else
            run_instr(ins, $urandom_range(1, 5), $urandom(), 1'($urandom_range(0, 1)));
`endif
        end

        // Reset in the second REQ cycle of a load, followed by a late ack
        ins = '0; ins.ld = 1'b1; ins.rw = 1'b1; ins.jal = 1'b1; ins.rd = 5'd9;
        ins.alu = 32'h500; ins.pc = 32'h80;
        drive_instr(ins);
        @(negedge clock);
        @(negedge clock);
        #1;
        check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ins   = '0;
        drive_instr(ins);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFEEDFACE;
        #1;
        check("post_rst_req",   {31'd0, dmem_req}, 32'd0);
        check("post_rst_state", {30'd0, dbg_state}, 32'd0);
        check_wb_zero("post_rst_wb");
        @(negedge clock);
        dmem_ack = 1'b0;
        #1;
        check("late_ack_req",   {31'd0, dmem_req}, 32'd0);
        check("late_ack_state", {30'd0, dbg_state}, 32'd0);
        check_wb_zero("late_ack_wb");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
